// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Instruction-fetch stage plus IF/ID pipeline register for the single-issue
// MIPS datapath. Owns the PC, talks to instruction memory with a req/ready
// handshake, parks one fetched word in a side buffer while decode is
// stalled, and flushes wrong-path work on a branch/jump redirect. Empty
// slots are presented to decode as an all-zero instruction (a NOP).
//
// Parameters:
//   RESET_PC     PC value loaded on reset
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   imem_req     fetch request, held until imem_ready
//   imem_addr    fetch address, stable while imem_req is high
//   imem_ready   memory accepts request; imem_rdata valid same cycle
//   imem_rdata   instruction word from memory
//   stall        decode cannot accept; IF/ID register holds
//   redirect     one-cycle pulse for a taken branch or jump
//   redirect_pc  new PC (bits [1:0] forced to zero)
//   id_valid     IF/ID holds a real instruction
//   id_instr     instruction to decode (0 when not valid)
//   id_pc4       PC+4 of id_instr (0 when not valid)
//   id_op        id_instr[31:26]
//   id_func      id_instr[5:0]
//
// Optional build macro IF_PERF_CNT_EN adds:
//   fetch_cnt    count of IF/ID loads carrying a valid instruction
//   bubble_cnt   count of IF/ID bubble loads, redirect flushes included
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_op,
    output logic [5:0]  id_func
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc4;
    logic [31:0] kill_addr;

    assign pc_plus4 = pc + 32'd4;

    // A KILL request cannot be withdrawn, so it keeps presenting the address
    // that was outstanding when the redirect hit; pc already points at the
    // redirect target by then.
    assign imem_req  = !rst && (state != S_HOLD);
    assign imem_addr = (state == S_KILL) ? kill_addr : pc;

    assign id_op   = id_instr[31:26];
    assign id_func = id_instr[5:0];

    // Redirect outranks stall: the flush must happen even when decode is
    // frozen, otherwise a wrong-path instruction would survive in IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            buf_instr <= 32'd0;
            buf_pc4   <= 32'd0;
            kill_addr <= 32'd0;
            id_valid  <= 1'b0;
            id_instr  <= 32'd0;
            id_pc4    <= 32'd0;
`ifdef IF_PERF_CNT_EN
            fetch_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
`endif
        end else if (redirect) begin
            id_valid <= 1'b0;
            id_instr <= 32'd0;
            id_pc4   <= 32'd0;
            pc       <= {redirect_pc[31:2], 2'b00};
`ifdef IF_PERF_CNT_EN
            bubble_cnt <= bubble_cnt + 32'd1;
`endif
            case (state)
                S_FETCH: begin
                    // A word arriving this cycle is simply dropped; an
                    // unanswered request has to be drained in KILL.
                    if (!imem_ready) begin
                        state     <= S_KILL;
                        kill_addr <= pc;
                    end
                end
                S_HOLD:  state <= S_FETCH;
                S_KILL:  state <= S_KILL;
                default: state <= S_FETCH;
            endcase
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready && !stall) begin
                        id_valid <= 1'b1;
                        id_instr <= imem_rdata;
                        id_pc4   <= pc_plus4;
                        pc       <= pc_plus4;
`ifdef IF_PERF_CNT_EN
                        fetch_cnt <= fetch_cnt + 32'd1;
`endif
                    end else if (imem_ready && stall) begin
                        buf_instr <= imem_rdata;
                        buf_pc4   <= pc_plus4;
                        pc        <= pc_plus4;
                        state     <= S_HOLD;
                    end else if (!imem_ready && !stall) begin
                        id_valid <= 1'b0;
                        id_instr <= 32'd0;
                        id_pc4   <= 32'd0;
`ifdef IF_PERF_CNT_EN
                        bubble_cnt <= bubble_cnt + 32'd1;
`endif
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_valid <= 1'b1;
                        id_instr <= buf_instr;
                        id_pc4   <= buf_pc4;
                        state    <= S_FETCH;
`ifdef IF_PERF_CNT_EN
                        fetch_cnt <= fetch_cnt + 32'd1;
`endif
                    end
                end
                S_KILL: begin
                    // IF/ID already holds the bubble written by the redirect.
                    if (imem_ready) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed bench for if_id_stage. A table of per-cycle records drives
// ready/stall/redirect and holds the hand-computed request address before
// the edge and IF/ID contents after the edge. Instruction memory returns
// its address XOR a pattern. Hand-written sequences follow for reset
// during KILL and op/func slicing with non-trivial instruction bits.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_op;
    logic [5:0]  id_func;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    logic [31:0] data_xor;

    localparam logic [1:0] LD_NONE   = 2'd0;
    localparam logic [1:0] LD_FETCH  = 2'd1;
    localparam logic [1:0] LD_BUBBLE = 2'd2;

    typedef struct {
        logic        ready;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic [1:0]  ld;
    } vec_t;

    vec_t vecs[$];

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_fetch;
    logic [31:0] exp_bubble;

    if_id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_op       (id_op),
        .id_func     (id_func)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    // Memory answers with garbage when not ready so a premature capture shows.
    assign imem_rdata = imem_ready ? (imem_addr ^ data_xor) : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic s, input logic rd,
                          input logic [31:0] rpc, input logic ereq,
                          input logic [31:0] eaddr, input logic evalid,
                          input logic [31:0] einstr, input logic [31:0] epc4,
                          input logic [1:0] ld);
        vec_t v;
        v.ready = r; v.stall = s; v.redirect = rd; v.rpc = rpc;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evalid;
        v.exp_instr = einstr; v.exp_pc4 = epc4; v.ld = ld;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [31:0] rpc);
        imem_ready  = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkRegs(input string tag, input logic evalid,
                             input logic [31:0] einstr, input logic [31:0] epc4);
        logic [31:0] e;
        e = einstr;
        checkOutput({tag, " id_valid"}, 32'(id_valid), 32'(evalid));
        checkOutput({tag, " id_instr"}, id_instr, einstr);
        checkOutput({tag, " id_pc4"}, id_pc4, epc4);
        checkOutput({tag, " id_op"}, 32'(id_op), 32'(e[31:26]));
        checkOutput({tag, " id_func"}, 32'(id_func), 32'(e[5:0]));
    endtask

    task automatic checkCounters(input string tag);
`ifdef IF_PERF_CNT_EN
        checkOutput({tag, " fetch_cnt"}, fetch_cnt, exp_fetch);
        checkOutput({tag, " bubble_cnt"}, bubble_cnt, exp_bubble);
`else
        checks = checks + 0;
`endif
    endtask

    task automatic countLoad(input logic [1:0] ld);
        if (ld == LD_FETCH)  exp_fetch  = exp_fetch + 32'd1;
        if (ld == LD_BUBBLE) exp_bubble = exp_bubble + 32'd1;
    endtask

    initial begin
        // ready, stall, redirect, rpc | req, addr | valid, instr, pc4 | load
        addVec(1,0,0,32'h0,        1,32'h0000_0000, 1,32'h0000_0000,32'h0000_0004, LD_FETCH);
        addVec(1,0,0,32'h0,        1,32'h0000_0004, 1,32'h0000_0004,32'h0000_0008, LD_FETCH);
        addVec(1,0,0,32'h0,        1,32'h0000_0008, 1,32'h0000_0008,32'h0000_000C, LD_FETCH);
        addVec(0,0,0,32'h0,        1,32'h0000_000C, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(0,0,0,32'h0,        1,32'h0000_000C, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(0,0,0,32'h0,        1,32'h0000_000C, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(1,0,0,32'h0,        1,32'h0000_000C, 1,32'h0000_000C,32'h0000_0010, LD_FETCH);
        addVec(1,1,0,32'h0,        1,32'h0000_0010, 1,32'h0000_000C,32'h0000_0010, LD_NONE);
        addVec(1,1,0,32'h0,        0,32'h0000_0014, 1,32'h0000_000C,32'h0000_0010, LD_NONE);
        addVec(1,1,0,32'h0,        0,32'h0000_0014, 1,32'h0000_000C,32'h0000_0010, LD_NONE);
        addVec(1,1,0,32'h0,        0,32'h0000_0014, 1,32'h0000_000C,32'h0000_0010, LD_NONE);
        addVec(1,0,0,32'h0,        0,32'h0000_0014, 1,32'h0000_0010,32'h0000_0014, LD_FETCH);
        addVec(1,0,0,32'h0,        1,32'h0000_0014, 1,32'h0000_0014,32'h0000_0018, LD_FETCH);
        addVec(0,0,1,32'h0000_0103,1,32'h0000_0018, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(0,0,0,32'h0,        1,32'h0000_0018, 0,32'h0,32'h0, LD_NONE);
        addVec(1,0,0,32'h0,        1,32'h0000_0018, 0,32'h0,32'h0, LD_NONE);
        addVec(1,0,0,32'h0,        1,32'h0000_0100, 1,32'h0000_0100,32'h0000_0104, LD_FETCH);
        addVec(1,0,0,32'h0,        1,32'h0000_0104, 1,32'h0000_0104,32'h0000_0108, LD_FETCH);
        addVec(1,1,0,32'h0,        1,32'h0000_0108, 1,32'h0000_0104,32'h0000_0108, LD_NONE);
        addVec(1,1,1,32'h0000_0200,0,32'h0000_010C, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(1,0,0,32'h0,        1,32'h0000_0200, 1,32'h0000_0200,32'h0000_0204, LD_FETCH);
        addVec(1,0,1,32'h0000_0300,1,32'h0000_0204, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(1,0,0,32'h0,        1,32'h0000_0300, 1,32'h0000_0300,32'h0000_0304, LD_FETCH);
        addVec(1,1,1,32'h0000_0400,1,32'h0000_0304, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(1,0,0,32'h0,        1,32'h0000_0400, 1,32'h0000_0400,32'h0000_0404, LD_FETCH);
        addVec(0,1,0,32'h0,        1,32'h0000_0404, 1,32'h0000_0400,32'h0000_0404, LD_NONE);
        addVec(1,0,0,32'h0,        1,32'h0000_0404, 1,32'h0000_0404,32'h0000_0408, LD_FETCH);
        addVec(0,0,1,32'h0000_0500,1,32'h0000_0408, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(0,0,1,32'h0000_0601,1,32'h0000_0408, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(1,0,0,32'h0,        1,32'h0000_0408, 0,32'h0,32'h0, LD_NONE);
        addVec(1,0,0,32'h0,        1,32'h0000_0600, 1,32'h0000_0600,32'h0000_0604, LD_FETCH);
        addVec(1,0,1,32'hFFFF_FFFB,1,32'h0000_0604, 0,32'h0,32'h0, LD_BUBBLE);
        addVec(1,0,0,32'h0,        1,32'hFFFF_FFF8, 1,32'hFFFF_FFF8,32'hFFFF_FFFC, LD_FETCH);
        addVec(1,0,0,32'h0,        1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,32'h0000_0000, LD_FETCH);
        addVec(1,0,0,32'h0,        1,32'h0000_0000, 1,32'h0000_0000,32'h0000_0004, LD_FETCH);

        exp_fetch  = 32'd0;
        exp_bubble = 32'd0;
        data_xor   = 32'd0;
        rst        = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

        #1;
        checkOutput("reset imem_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        checkOutput("reset imem_req held", 32'(imem_req), 32'd0);
        checkRegs("reset", 1'b0, 32'd0, 32'd0);
        checkCounters("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ready, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            #1;
            checkOutput($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req)
                checkOutput($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
            @(posedge clk); #1;
            countLoad(vecs[i].ld);
            checkRegs($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_instr,
                      vecs[i].exp_pc4);
            checkCounters($sformatf("v%0d", i));
        end

        // Enter KILL, then reset while the request is still outstanding.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0700);
        #1;
        checkOutput("kill entry imem_addr", imem_addr, 32'h0000_0004);
        @(posedge clk); #1;
        countLoad(LD_BUBBLE);
        checkRegs("kill entry", 1'b0, 32'd0, 32'd0);
        checkCounters("kill entry");

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        checkOutput("rst in kill imem_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        exp_fetch  = 32'd0;
        exp_bubble = 32'd0;
        checkRegs("rst in kill", 1'b0, 32'd0, 32'd0);
        checkCounters("rst in kill");

        // Restart from RESET_PC with op/func bits populated.
        rst      = 1'b0;
        data_xor = 32'hFC00_003F;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        #1;
        checkOutput("restart imem_req", 32'(imem_req), 32'd1);
        checkOutput("restart imem_addr", imem_addr, 32'h0000_0000);
        @(posedge clk); #1;
        countLoad(LD_FETCH);
        checkRegs("restart w0", 1'b1, 32'hFC00_003F, 32'h0000_0004);
        #1;
        checkOutput("restart imem_addr 2", imem_addr, 32'h0000_0004);
        @(posedge clk); #1;
        countLoad(LD_FETCH);
        checkRegs("restart w1", 1'b1, 32'hFC00_003B, 32'h0000_0008);
        checkCounters("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
